// File: rtl/serv_pc_seq.sv
// serv_pc_seq: instruction sequencer for the serial PC/control datapath.
// Each instruction walks through FETCH -> WAIT -> RUN. The block drives the
// instruction-bus request and the PC update enable. It also generates the
// bit-position strobes used by the PC datapath while a run is in progress.
// Trap requests are captured only at the instruction boundary (WAIT exit).
// W selects the datapath width: 1 bit or 4 bits per cycle.

module serv_pc_seq #(
  parameter  int W = 1,
  localparam int B = W - 1
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_ibus_ack,
  input  logic       i_exec_ready,
  input  logic       i_trap_req,
  output logic       o_ibus_cyc,
  output logic       o_pc_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt03,
  output logic       o_cnt12to31,
  output logic       o_cnt_done,
  output logic       o_trap
);

  // Bit index advance per RUN cycle, and the index of the final slice.
  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);
  // Highest offset inside one slice, relative to the slice base.
  localparam logic [4:0] SPAN = 5'(B);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       trap_lat;
  logic       ibus_cyc;
  logic       run_s;

  // True when bit k falls inside the slice whose lowest bit is p.
  // Unsigned subtraction wraps when k < p, so the p <= k guard is required.
  function automatic logic slice_has(input logic [4:0] p, input logic [4:0] k);
    logic [4:0] off;
    off = k - p;
    return (p <= k) && (off <= SPAN);
  endfunction

  // Sequencer state, run counter, trap latch and the registered bus request.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      trap_lat <= 1'b0;
      ibus_cyc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Leave IDLE on the first clock after reset and request a fetch.
          state    <= FETCH;
          cnt      <= 5'd0;
          trap_lat <= 1'b0;
          ibus_cyc <= 1'b1;
        end
        FETCH: begin
          // Ack latency is unbounded. The request stays high until the ack.
          if (i_ibus_ack) begin
            state    <= WAIT;
            ibus_cyc <= 1'b0;
          end else begin
            state    <= FETCH;
            ibus_cyc <= 1'b1;
          end
        end
        WAIT: begin
          // The instruction boundary: the trap request is sampled here only.
          if (i_exec_ready) begin
            state    <= RUN;
            cnt      <= 5'd0;
            trap_lat <= i_trap_req;
          end else begin
            state    <= WAIT;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            // Last slice: go straight back to fetching the next instruction.
            state    <= FETCH;
            cnt      <= 5'd0;
            trap_lat <= 1'b0;
            ibus_cyc <= 1'b1;
          end else begin
            state    <= RUN;
            cnt      <= cnt + STEP;
          end
        end
        default: begin
          // Unreachable encodings recover to a clean IDLE.
          state    <= IDLE;
          cnt      <= 5'd0;
          trap_lat <= 1'b0;
          ibus_cyc <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: the strobes follow the counter and are forced low outside RUN.
  always_comb begin
    run_s       = (state == RUN);
    o_ibus_cyc  = ibus_cyc;
    o_pc_en     = 1'b0;
    o_cnt       = 5'd0;
    o_cnt0      = 1'b0;
    o_cnt1      = 1'b0;
    o_cnt2      = 1'b0;
    o_cnt03     = 1'b0;
    o_cnt12to31 = 1'b0;
    o_cnt_done  = 1'b0;
    o_trap      = 1'b0;
    if (run_s) begin
      o_pc_en     = 1'b1;
      o_cnt       = cnt;
      o_cnt0      = slice_has(cnt, 5'd0);
      o_cnt1      = slice_has(cnt, 5'd1);
      o_cnt2      = slice_has(cnt, 5'd2);
      o_cnt03     = (cnt < 5'd4);
      o_cnt12to31 = (cnt >= 5'd12);
      o_cnt_done  = (cnt == LAST);
      o_trap      = trap_lat;
    end else begin
      o_pc_en     = 1'b0;
    end
  end

endmodule

// File: tb/tb_serv_pc_seq.sv
// Testbench for serv_pc_seq. It instantiates one W=1 device and one W=4 device.
// Each instruction is replayed against a per-cycle reference model.
// The model is built from the phase the instruction is in (fetch, wait or run)
// and from the bit position p = cycle*W of the current run cycle.
module tb_serv_pc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0 drives the W=1 device, index 1 drives the W=4 device.
  logic [1:0] rstn, ack, rdy, trq;
  logic [1:0] cyc, pce, c0, c1, c2, c03, c12, dn, trp;
  logic [4:0] cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  serv_pc_seq #(.W(1)) dut1 (
    .clk(clk), .i_rst_n(rstn[0]), .i_ibus_ack(ack[0]), .i_exec_ready(rdy[0]),
    .i_trap_req(trq[0]), .o_ibus_cyc(cyc[0]), .o_pc_en(pce[0]), .o_cnt(cnt_a),
    .o_cnt0(c0[0]), .o_cnt1(c1[0]), .o_cnt2(c2[0]), .o_cnt03(c03[0]),
    .o_cnt12to31(c12[0]), .o_cnt_done(dn[0]), .o_trap(trp[0])
  );

  serv_pc_seq #(.W(4)) dut4 (
    .clk(clk), .i_rst_n(rstn[1]), .i_ibus_ack(ack[1]), .i_exec_ready(rdy[1]),
    .i_trap_req(trq[1]), .o_ibus_cyc(cyc[1]), .o_pc_en(pce[1]), .o_cnt(cnt_b),
    .o_cnt0(c0[1]), .o_cnt1(c1[1]), .o_cnt2(c2[1]), .o_cnt03(c03[1]),
    .o_cnt12to31(c12[1]), .o_cnt_done(dn[1]), .o_trap(trp[1])
  );

  // Packs the outputs of one device as
  // {cyc, pc_en, cnt0, cnt1, cnt2, cnt03, cnt12to31, done, trap, cnt}.
  function automatic logic [13:0] obs(input int d);
    logic [4:0] c;
    c = (d == 0) ? cnt_a : cnt_b;
    return {cyc[d], pce[d], c0[d], c1[d], c2[d], c03[d], c12[d], dn[d], trp[d], c};
  endfunction

  // Reference model for one cycle, taken from the rules of each phase.
  function automatic logic [13:0] exp_vec(input bit cyc_e, input bit run, input int p,
                                          input int w, input bit last, input bit trap_e);
    if (!run)
      return {cyc_e, 13'd0};
    return {1'b0, 1'b1, 1'(p <= 0 && 0 < p + w), 1'(p <= 1 && 1 < p + w),
            1'(p <= 2 && 2 < p + w), 1'(p < 4), 1'(p >= 12), last, trap_e, 5'(p)};
  endfunction

  // One instruction on device d, starting at the first FETCH cycle.
  // If stop_at >= 0, the task returns after checking that run cycle.
  task automatic do_instr(input int d, input int ack_lat, input int rdy_lat,
                          input bit tb, input bit tied, input int stop_at);
    int w;
    int n;
    logic [13:0] o, e;
    w = (d != 0) ? 4 : 1;
    n = 32 / w;
    for (int i = 0; i <= ack_lat; i++) begin
      @(negedge clk);
      o = obs(d); e = exp_vec(1'b1, 1'b0, 0, w, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL fetch d=%0d i=%0d got=%b want=%b", d, i, o, e); end
      ack[d] = tied ? 1'b1 : 1'(i == ack_lat);
      rdy[d] = tied ? 1'b1 : 1'($urandom_range(0, 1));
      trq[d] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i <= rdy_lat; i++) begin
      @(negedge clk);
      o = obs(d); e = exp_vec(1'b0, 1'b0, 0, w, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL wait d=%0d i=%0d got=%b want=%b", d, i, o, e); end
      ack[d] = tied ? 1'b1 : 1'($urandom_range(0, 1));
      rdy[d] = tied ? 1'b1 : 1'(i == rdy_lat);
      trq[d] = (i == rdy_lat) ? tb : 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      o = obs(d); e = exp_vec(1'b0, 1'b1, c * w, w, 1'(c == n - 1), tb);
      checks++;
      if (o !== e) begin errors++; $display("FAIL run d=%0d c=%0d got=%b want=%b", d, c, o, e); end
      if (c == stop_at) return;
      ack[d] = tied ? 1'b1 : 1'($urandom_range(0, 1));
      rdy[d] = tied ? 1'b1 : 1'($urandom_range(0, 1));
      trq[d] = 1'($urandom_range(0, 1));
    end
    ack[d] = 1'b0; rdy[d] = 1'b0; trq[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] o;
    rstn = 2'b00; ack = 2'b11; rdy = 2'b11; trq = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = obs(d); checks++;
      if (o !== 14'd0) begin errors++; $display("FAIL reset d=%0d got=%b want=0", d, o); end
    end
    ack = 2'b00; rdy = 2'b00; trq = 2'b00;
    rstn = 2'b11;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = obs(d); checks++;
      if (o !== 14'd0) begin errors++; $display("FAIL idle d=%0d got=%b want=0", d, o); end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = obs(d); checks++;
        if (o !== {1'b1, 13'd0}) begin
          errors++; $display("FAIL fetch_hold d=%0d i=%0d got=%b want=%b", d, i, o, {1'b1, 13'd0});
        end
      end
    end
  endtask

  task automatic test_run_w1();
    do_instr(0, 3, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_w4_tied();
    do_instr(1, 0, 0, 1'b0, 1'b1, -1);
    do_instr(1, 0, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_trap();
    do_instr(0, 2, 1, 1'b0, 1'b0, -1);
    do_instr(0, 0, 0, 1'b1, 1'b0, -1);
    do_instr(0, 1, 0, 1'b0, 1'b0, -1);
    do_instr(1, 1, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_run();
    logic [13:0] o;
    do_instr(0, 0, 0, 1'b1, 1'b0, 10);
    rstn[0] = 1'b0;
    #1;
    o = obs(0); checks++;
    if (o !== 14'd0) begin errors++; $display("FAIL async_reset got=%b want=0", o); end
    @(negedge clk);
    o = obs(0); checks++;
    if (o !== 14'd0) begin errors++; $display("FAIL reset_hold got=%b want=0", o); end
    ack[0] = 1'b0; rdy[0] = 1'b0; trq[0] = 1'b0;
    rstn[0] = 1'b1;
    #1;
    o = obs(0); checks++;
    if (o !== 14'd0) begin errors++; $display("FAIL reset_idle got=%b want=0", o); end
    do_instr(0, 1, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      do_instr(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    do_instr(0, 0, 0, 1'b1, 1'b0, -1);
    do_instr(0, 0, 0, 1'b0, 1'b0, -1);
    do_instr(1, 0, 0, 1'b1, 1'b0, -1);
    do_instr(1, 0, 0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rstn = 2'b00; ack = 2'b00; rdy = 2'b00; trq = 2'b00;
    test_reset();
    test_run_w1();
    test_w4_tied();
    test_trap();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_pc_seq.md
Name: serv_pc_seq

Overview:
Sequencer for the serial PC/control datapath. Runs a fetch → wait-operands → serial-run loop per instruction. Drives the instruction-bus request and the PC-update enable. Generates the bit-position strobes (cnt0, cnt1, cnt2, cnt03, cnt12to31) consumed by the PC datapath, and latches trap requests at instruction boundaries.

Parameters:
- W, 1, datapath bits per cycle; legal values 1 and 4 only; a run lasts 32/W cycles.
- B, W-1, MSB index of per-cycle datapath slices (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ibus_ack  input  1  instruction bus acknowledge; ignored outside FETCH.
- i_exec_ready  input  1  operands/decoder ready; ignored outside WAIT.
- i_trap_req  input  1  trap/interrupt pending; sampled only on the WAIT→RUN transition.
- o_ibus_cyc  output  1  instruction fetch request (registered).
- o_pc_en  output  1  PC shift/update enable; high for every RUN cycle.
- o_cnt  output  5  current bit index of the run (cycle*W); 0 outside RUN.
- o_cnt0  output  1  bit 0 is in the current slice.
- o_cnt1  output  1  bit 1 is in the current slice.
- o_cnt2  output  1  bit 2 is in the current slice.
- o_cnt03  output  1  any of bits 0..3 is in the current slice.
- o_cnt12to31  output  1  current slice lies within bits 12..31.
- o_cnt_done  output  1  last cycle of the run.
- o_trap  output  1  latched trap flag; valid throughout RUN.

Behaviour:
- States: IDLE, FETCH, WAIT, RUN; 2-bit encoded register.
- Async reset (i_rst_n=0):
  - state=IDLE, counter=0, trap latch=0, o_ibus_cyc=0.
  - All outputs 0 while reset is asserted and in the first IDLE cycle.
- IDLE → FETCH unconditionally on the first clock after reset release.
- FETCH:
  - o_ibus_cyc=1 from the first FETCH cycle; it is a registered output, set on the IDLE→FETCH and RUN→FETCH edges.
  - On i_ibus_ack=1: next state WAIT; o_ibus_cyc=0 in the following cycle.
  - Ack latency is unbounded. An ack in the same cycle as FETCH entry is legal and gives exactly one FETCH cycle.
- WAIT:
  - Hold while i_exec_ready=0.
  - On i_exec_ready=1: next state RUN; counter←0; trap latch←i_trap_req.
- RUN:
  - o_pc_en=1 on every cycle; counter increments by W each cycle.
  - o_cnt_done=1 when counter==32-W; next state FETCH, counter←0.
  - Run length is exactly 32/W cycles: 32 for W=1, 8 for W=4.
- Strobes:
  - Combinational from the counter, forced 0 outside RUN.
  - With p=o_cnt, strobe cntK=1 iff p ≤ K < p+W.
  - o_cnt03=1 iff p<4.
  - o_cnt12to31=1 iff p≥12.
  - For W=4, cnt0/cnt1/cnt2/cnt03 are all high together in cycle 0.
- o_trap: equals the latch during RUN, 0 otherwise. The latch is cleared on RUN→FETCH.
- Boundary conditions:
  - i_trap_req during FETCH or RUN has no effect; it is re-sampled at the next WAIT exit.
  - i_ibus_ack in WAIT/RUN/IDLE is ignored.
  - i_exec_ready outside WAIT is ignored.
  - Counter arithmetic is 5-bit and wraps to 0 only through the explicit clear; no overflow is reachable.
  - Reset asserted mid-RUN or mid-FETCH immediately (asynchronously) drops o_pc_en and o_ibus_cyc and clears all state. No partial-run completion.
  - The bus request is abandoned; the bus side must tolerate cyc dropping without ack.
- Latency: last RUN cycle → o_ibus_cyc=1 on the next cycle. Minimum instruction period is 1 FETCH + 1 WAIT + 32/W RUN cycles.

Test Plan:
- Reset release, W=1, ack held 0: IDLE one cycle, then o_ibus_cyc=1 from cycle 2 onward. o_pc_en=0 throughout.
- W=1, ack after 3 FETCH cycles, exec_ready after 2 WAIT cycles → o_pc_en high exactly 32 cycles.
  - o_cnt0 only in run cycle 0, o_cnt1 only in cycle 1, o_cnt2 only in cycle 2.
  - o_cnt03 in cycles 0–3; o_cnt12to31 in cycles 12–31.
  - o_cnt_done in cycle 31; o_ibus_cyc=1 the next cycle.
- W=4, ack and exec_ready both tied 1 → 10-cycle period (FETCH, WAIT, 8 RUN).
  - o_cnt = 0,4,…,28.
  - cnt0/1/2/03 all high only in run cycle 0; o_cnt12to31 in run cycles 3–7.
- i_trap_req pulsed during FETCH only → o_trap=0 in that run.
- i_trap_req=1 coincident with i_exec_ready=1 → o_trap=1 for all RUN cycles, 0 in the following FETCH.
- i_rst_n driven low in run cycle 10 (W=1) → o_pc_en and o_cnt drop without a clock edge.
  - After release: IDLE then FETCH; the next run starts at o_cnt=0 and lasts a full 32 cycles.
